alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_op_decode.sv | 31 +++
 rtl/alu_op_sequencer.sv | 109 ++++++++++
 tb/tb_alu_op_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU op sequencer: ALU control codes, op classes,
// R-type funct values and the sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;

  localparam logic [1:0] ALUOP_ADD     = 2'b00;
  localparam logic [1:0] ALUOP_SUB     = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT   = 2'b10;
  localparam logic [1:0] ALUOP_ILLEGAL = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decoder: op class plus R-type funct to a 4-bit ALU control
// code, with a flag for encodings the ALU does not support.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] control,
  output logic       illegal
);

  always_comb begin
    control = CTRL_AND;
    illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: control = CTRL_ADD;
      ALUOP_SUB: control = CTRL_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: control = CTRL_ADD;
          FUNCT_SUB: control = CTRL_SUB;
          FUNCT_AND: control = CTRL_AND;
          FUNCT_OR:  control = CTRL_OR;
          default:   illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation per request: decode, drive registered operands
// for one cycle, then hold the response. Define ALU_SEQ_PIPE_EN for back-to-back mode.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_aluop,
  input  logic [5:0]       req_funct,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [3:0]       alu_control,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_illegal,
  output state_t           fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // valid never depends on ready; payload is held while valid && !ready.

  state_t     state, state_next;
  logic [3:0] dec_control;
  logic       dec_illegal;
  logic       accept;
  logic       load_op;
  logic       load_illegal;
  logic       capture;

  alu_op_decode u_decode (
    .aluop   (req_aluop),
    .funct   (req_funct),
    .control (dec_control),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    req_ready  = (state == IDLE);
`ifdef ALU_SEQ_PIPE_EN
    // A new request may ride on the same edge that retires the response.
    if (state == RESP) req_ready = rsp_ready;
`endif
    accept = req_valid && req_ready;
    case (state)
      IDLE: begin
        if (accept) state_next = dec_illegal ? RESP : EXEC;
      end
      EXEC: begin
        capture    = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
          if (accept) state_next = dec_illegal ? RESP : EXEC;
        end
      end
      default: state_next = IDLE;
    endcase
    load_op      = accept && !dec_illegal;
    load_illegal = accept && dec_illegal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      alu_control <= 4'b0000;
      alu_a       <= '0;
      alu_b       <= '0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (load_op) begin
        alu_control <= dec_control;
        alu_a       <= req_a;
        alu_b       <= req_b;
      end
      // Illegal requests leave the ALU-facing registers untouched.
      if (load_illegal) begin
        rsp_result  <= '0;
        rsp_zero    <= 1'b0;
        rsp_illegal <= 1'b1;
      end
      if (capture) begin
        rsp_result  <= alu_result;
        rsp_zero    <= alu_zero;
        rsp_illegal <= 1'b0;
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign fsm_state = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed spec cases plus random
// ops scored against an arithmetic reference model.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_aluop;
  logic [5:0]       req_funct;
  logic [WIDTH-1:0] req_a, req_b;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_illegal;
  state_t           fsm_state;

  int checks   = 0;
  int failures = 0;

  // Model state: the ALU-facing registers as the spec says they should read.
  logic [3:0]       exp_ctrl;
  logic [WIDTH-1:0] exp_a, exp_b;

  alu_op_sequencer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_aluop   (req_aluop),
    .req_funct   (req_funct),
    .req_a       (req_a),
    .req_b       (req_b),
    .alu_control (alu_control),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .rsp_illegal (rsp_illegal),
    .fsm_state   (fsm_state)
  );

  always #5 clk = ~clk;

  // Environment ALU driven by the sequencer's registered outputs.
  always_comb begin
    case (alu_control)
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: what the op means, independent of how it is encoded downstream.
  task automatic model(input logic [1:0] op, input logic [5:0] fn,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       output logic illegal, output logic [3:0] ctrl,
                       output logic [WIDTH-1:0] res);
    illegal = 1'b0;
    ctrl    = 4'b0000;
    res     = '0;
    if (op == 2'b00 || (op == 2'b10 && fn == 6'b100000)) begin
      ctrl = 4'b0010; res = WIDTH'((int'(a) + int'(b)) % 256);
    end else if (op == 2'b01 || (op == 2'b10 && fn == 6'b100010)) begin
      ctrl = 4'b0110; res = WIDTH'((int'(a) - int'(b) + 256) % 256);
    end else if (op == 2'b10 && fn == 6'b100100) begin
      ctrl = 4'b0000; res = a & b;
    end else if (op == 2'b10 && fn == 6'b100101) begin
      ctrl = 4'b0001; res = a | b;
    end else begin
      illegal = 1'b1;
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [5:0] fn,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input int hold);
    logic             ill;
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] res;
    model(op, fn, a, b, ill, ctrl, res);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_aluop = op; req_funct = fn; req_a = a; req_b = b;
    rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    if (!ill) begin
      exp_ctrl = ctrl; exp_a = a; exp_b = b;
      check("exec_rsp_valid", rsp_valid, 0);
      check("exec_req_ready", req_ready, 0);
      check("exec_alu_control", alu_control, exp_ctrl);
      check("exec_alu_a", alu_a, exp_a);
      check("exec_alu_b", alu_b, exp_b);
      tick();
    end
    check("rsp_valid", rsp_valid, 1);
    check("rsp_result", rsp_result, res);
    check("rsp_zero", rsp_zero, (!ill && res == 0) ? 1 : 0);
    check("rsp_illegal", rsp_illegal, ill);
    check("rsp_alu_control", alu_control, exp_ctrl);
    check("rsp_alu_a", alu_a, exp_a);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_result", rsp_result, res);
      check("hold_rsp_illegal", rsp_illegal, ill);
      check("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("after_rsp_valid", rsp_valid, 0);
    check("after_req_ready", req_ready, 1);
  endtask

  initial begin
    logic [1:0]       r_op;
    logic [5:0]       r_fn;
    logic [5:0]       legal_fn [4];
    legal_fn[0] = 6'b100000; legal_fn[1] = 6'b100010;
    legal_fn[2] = 6'b100100; legal_fn[3] = 6'b100101;

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_aluop = 2'b00; req_funct = 6'd0; req_a = '0; req_b = '0;
    exp_ctrl = 4'b0000; exp_a = '0; exp_b = '0;
    tick(); tick();
    rst = 1'b0;

    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_req_ready", req_ready, 1);
    check("reset_alu_control", alu_control, 0);
    check("reset_rsp_result", rsp_result, 0);
    check("reset_state", fsm_state, IDLE);

    // Directed: add overflow into the sign bit, sub to zero, sub wrap, illegal funct.
    do_op(2'b10, 6'b100000, 8'h7F, 8'h01, 0);
    do_op(2'b01, 6'b000000, 8'h35, 8'h35, 0);
    do_op(2'b01, 6'b000000, 8'h00, 8'h01, 0);
    do_op(2'b10, 6'b101010, 8'h12, 8'h34, 0);
    do_op(2'b11, 6'b100000, 8'h12, 8'h34, 0);
    do_op(2'b10, 6'b100100, 8'hF0, 8'h3C, 5);

    // Reset while in EXEC discards the request.
    req_valid = 1'b1; req_aluop = 2'b00; req_a = 8'h11; req_b = 8'h22;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ctrl = 4'b0000; exp_a = '0; exp_b = '0;
    check("rst_exec_rsp_valid", rsp_valid, 0);
    check("rst_exec_req_ready", req_ready, 1);
    check("rst_exec_alu_control", alu_control, 0);
    check("rst_exec_alu_a", alu_a, 0);
    check("rst_exec_alu_b", alu_b, 0);
    check("rst_exec_rsp_result", rsp_result, 0);
    check("rst_exec_rsp_zero", rsp_zero, 0);
    check("rst_exec_rsp_illegal", rsp_illegal, 0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_exec_no_rsp", rsp_valid, 0);
    end
    rsp_ready = 1'b0;

    // Random ops, mostly legal funct values.
    for (int n = 0; n < 24; n++) begin
      r_op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) r_fn = 6'($urandom_range(0, 63));
      else r_fn = legal_fn[$urandom_range(0, 3)];
      do_op(r_op, r_fn, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            int'($urandom_range(0, 3)));
    end

`ifdef ALU_SEQ_PIPE_EN
    // Back-to-back: AND then OR, one op every two cycles.
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_aluop = 2'b10; req_funct = 6'b100100;
    req_a = 8'hF0; req_b = 8'h3C;
    tick();
    req_funct = 6'b100101; req_a = 8'hF0; req_b = 8'h0F;
    tick();
    check("pipe_rsp0_valid", rsp_valid, 1);
    check("pipe_rsp0_result", rsp_result, 8'h30);
    check("pipe_req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("pipe_exec_rsp_valid", rsp_valid, 0);
    tick();
    check("pipe_rsp1_valid", rsp_valid, 1);
    check("pipe_rsp1_result", rsp_result, 8'hFF);
    tick();
    check("pipe_idle", rsp_valid, 0);
    rsp_ready = 1'b0;
`else
    // Without back-to-back mode a ready response side must not open the request side.
    req_valid = 1'b1; req_aluop = 2'b00; req_a = 8'h01; req_b = 8'h02;
    tick();
    req_valid = 1'b0;
    tick();
    rsp_ready = 1'b1;
    check("nopipe_req_ready_resp", req_ready, 0);
    check("nopipe_rsp_result", rsp_result, 8'h03);
    tick();
    rsp_ready = 1'b0;
    check("nopipe_idle", rsp_valid, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
